syscall_unit: RTL and testbench
===============================

// Module: syscall_unit
// PURPOSE
//  Services SYSCALL instructions retiring from the writeback stage of the 5-stage MIPS pipeline.
//  Decodes $v0 and emits console output: print_int, print_string, print_char.
//  Handles exit.
//  Holds the pipeline (stall) while a multi-cycle service runs.
//  print_string walks data memory through a private read port.
// PARAMETERS
//  MAX_STR_LEN  256  max chars emitted per print_string; the walk ends early at this limit.
// PORTS
//  clk            in   1   pipeline clock, rising-edge.
//  reset          in   1   asynchronous, active-high.
//  syscall_valid  in   1   SYSCALL present in writeback this cycle.
//  v0             in   32  service code.
//  a0             in   32  argument: int value, string byte address, or char.
//  a1             in   32  reserved, unused in this version.
//  mem_rd         out  1   data-memory read strobe.
//  mem_addr       out  32  word-aligned read address ({addr[31:2],2'b00}).
//  mem_rdata      in   32  read data, valid the cycle after mem_rd.
//  char_valid     out  1   console char available.
//  char_data      out  8   ASCII char.
//  char_ready     in   1   console accepts char when char_valid & char_ready.
//  int_valid      out  1   console int available.
//  int_data       out  32  signed int for print_int.
//  int_ready      in   1   int handshake accept.
//  stall          out  1   freezes F/D/E/M/W registers (OR'd into hazard stalls).
//  halted         out  1   sticky exit flag.
//  bad_code       out  1   one-cycle pulse on an unsupported v0.
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE.
//   - mem_rd, char_valid, int_valid, halted, bad_code = 0.
//   - mem_addr, char_data, int_data, str_ptr, count = 0.
//  Reset mid-service aborts immediately; no partial char remains valid.
//  States: IDLE, STR_RD, STR_WAIT, STR_EMIT, CHAR_EMIT, INT_EMIT, HALT.
//  IDLE:
//   - Acts on syscall_valid only. v0 and a0 are sampled at the accepting edge.
//   - v0=1  -> INT_EMIT; int_data<=a0.
//   - v0=4  -> STR_RD; str_ptr<=a0; count<=0.
//   - v0=10 -> HALT.
//   - v0=11 -> CHAR_EMIT; char_data<=a0[7:0].
//   - Any other code: bad_code pulses, state stays IDLE, no stall.
//  stall (combinational):
//   - 1 when (IDLE & syscall_valid & v0 in {1,4,11,10}).
//   - 1 in every state other than IDLE, including HALT.
//   - Result: the SYSCALL stays in writeback until service completes, and only one service runs per SYSCALL.
//   - On the final cycle of a service (handshake completes), stall is still 1. The next cycle is IDLE.
//   - The unit ignores syscall_valid for exactly one cycle after returning to IDLE, so the held SYSCALL is not re-executed.
//  INT_EMIT:
//   - int_valid=1; int_data is stable until int_ready.
//   - On accept -> IDLE.
//  CHAR_EMIT:
//   - char_valid=1 until char_ready.
//   - On accept -> IDLE.
//  STR_RD:
//   - mem_rd=1 for one cycle; mem_addr = word of str_ptr.
//   - -> STR_WAIT.
//  STR_WAIT:
//   - Selects byte b = mem_rdata[8*str_ptr[1:0] +: 8] (little-endian).
//   - b==0 -> IDLE.
//   - Otherwise char_data<=b -> STR_EMIT.
//  STR_EMIT:
//   - char_valid=1 until char_ready.
//   - On accept: str_ptr+=1 (32-bit wrap at 0xFFFFFFFF->0), count+=1.
//   - Then -> IDLE if count+1==MAX_STR_LEN, else -> STR_RD.
//  Each character is read individually: every char re-reads its word; no word caching.
//  HALT:
//   - halted=1, stall=1 permanently.
//   - syscall_valid is ignored.
//   - Only reset leaves HALT.
//  Latency (ready held high):
//   - char/int: 1 cycle to accept, plus 1 cycle before IDLE.
//   - string: 3 cycles per char, plus 2 cycles for the NUL terminator.
//  char_valid and int_valid are never high together. Outputs change only on clk or reset.
// TESTING
//  T1 reset: assert reset mid-STR_EMIT -> all outputs 0, state IDLE, halted=0.
//  T2 print_char:
//     - Stimulus: v0=11, a0=0x41, char_ready low for 3 cycles.
//     - Response: char_valid held with char_data=0x41 and stall=1; one char accepted; stall drops 1 cycle after accept.
//  T3 print_string:
//     - Stimulus: memory word 0x100=0x006C6548 ("Hel",NUL), v0=4, a0=0x100.
//     - Response: chars 0x48,0x65,0x6C in order; reads at 0x100 only; done at NUL.
//  T4 unaligned/limit:
//     - a0=0x103 crossing into word 0x104 -> correct byte select across the word boundary.
//     - MAX_STR_LEN=4 on an 8-char string -> exactly 4 chars emitted.
//  T5 print_int: v0=1, a0=0xFFFFFFF6 -> int_data=-10, single int handshake.
//  T6 exit/bad:
//     - v0=10 -> halted=1 and stall=1 forever; a later syscall_valid is ignored.
//     - v0=7 -> bad_code 1-cycle pulse, stall=0.

Source files
------------

// File: rtl/syscall_unit.sv
// Services SYSCALLs held in writeback: print_int, print_string, print_char and exit.
// print_string fetches one byte per data-memory read through a private read port.
`timescale 1ns/1ps
module syscall_unit #(
  parameter int MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_valid,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        int_valid,
  output logic [31:0] int_data,
  input  logic        int_ready,
  output logic        stall,
  output logic        halted,
  output logic        bad_code
);

  localparam int CW = $clog2(MAX_STR_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    STR_RD,
    STR_WAIT,
    STR_EMIT,
    CHAR_EMIT,
    INT_EMIT,
    HALT
  } state_t;

  state_t        state;
  logic [31:0]   str_ptr;
  logic [CW-1:0] count;
  logic          skip;
  logic          supported;
  logic [7:0]    cur_byte;
  logic [31:0]   count_next;
  logic [31:0]   ptr_next;
  logic          unused_a1;

  assign unused_a1  = ^a1;
  assign supported  = (v0 == 32'd1) || (v0 == 32'd4) || (v0 == 32'd10) || (v0 == 32'd11);
  assign cur_byte   = mem_rdata[{str_ptr[1:0], 3'b000} +: 8];
  assign count_next = 32'(count) + 32'd1;
  assign ptr_next   = str_ptr + 32'd1;

  // The held SYSCALL is stalled from the accepting cycle until the unit is back in IDLE.
  assign stall = (state != IDLE) || (syscall_valid && !skip && supported);

  // skip marks the first IDLE cycle after a service, when the same SYSCALL is still in writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
      int_valid  <= 1'b0;
      int_data   <= '0;
      halted     <= 1'b0;
      bad_code   <= 1'b0;
      str_ptr    <= '0;
      count      <= '0;
      skip       <= 1'b0;
    end else begin
      bad_code <= 1'b0;
      mem_rd   <= 1'b0;
      skip     <= 1'b0;
      case (state)
        IDLE: begin
          if (syscall_valid && !skip) begin
            case (v0)
              32'd1: begin
                int_data  <= a0;
                int_valid <= 1'b1;
                state     <= INT_EMIT;
              end
              32'd4: begin
                str_ptr  <= a0;
                count    <= '0;
                mem_rd   <= 1'b1;
                mem_addr <= {a0[31:2], 2'b00};
                state    <= STR_RD;
              end
              32'd10: begin
                halted <= 1'b1;
                state  <= HALT;
              end
              32'd11: begin
                char_data  <= a0[7:0];
                char_valid <= 1'b1;
                state      <= CHAR_EMIT;
              end
              default: bad_code <= 1'b1;
            endcase
          end
        end
        STR_RD: state <= STR_WAIT;
        STR_WAIT: begin
          if (cur_byte == 8'h00) begin
            state <= IDLE;
            skip  <= 1'b1;
          end else begin
            char_data  <= cur_byte;
            char_valid <= 1'b1;
            state      <= STR_EMIT;
          end
        end
        STR_EMIT: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            str_ptr    <= ptr_next;
            count      <= count_next[CW-1:0];
            // Every character re-reads its word; no caching across bytes.
            if (count_next == 32'(MAX_STR_LEN)) begin
              state <= IDLE;
              skip  <= 1'b1;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= {ptr_next[31:2], 2'b00};
              state    <= STR_RD;
            end
          end
        end
        CHAR_EMIT: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            state      <= IDLE;
            skip       <= 1'b1;
          end
        end
        INT_EMIT: begin
          if (int_ready) begin
            int_valid <= 1'b0;
            state     <= IDLE;
            skip      <= 1'b1;
          end
        end
        HALT: halted <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Randomized bench for syscall_unit: a byte-level memory model predicts console output
// and read addresses; a second instance with MAX_STR_LEN=4 covers the string length limit.
`timescale 1ns/1ps
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_valid, syscall_valid_lim;
  logic [31:0] v0, a0, a1;
  logic        char_ready, int_ready;
  logic        mem_rd, char_valid, int_valid, stall, halted, bad_code;
  logic [31:0] mem_addr, mem_rdata, int_data;
  logic [7:0]  char_data;
  logic        mem_rd_lim, char_valid_lim, int_valid_lim, stall_lim, halted_lim, bad_code_lim;
  logic [31:0] mem_addr_lim, mem_rdata_lim, int_data_lim;
  logic [7:0]  char_data_lim;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  char_q[$], char_lim_q[$], exp_chars[$];
  logic [31:0] int_q[$], rd_q[$], rd_lim_q[$], exp_reads[$];

  always #5 clk = ~clk;

  syscall_unit dut (
    .clk(clk), .reset(reset), .syscall_valid(syscall_valid), .v0(v0), .a0(a0), .a1(a1),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .int_valid(int_valid), .int_data(int_data), .int_ready(int_ready),
    .stall(stall), .halted(halted), .bad_code(bad_code)
  );

  syscall_unit #(.MAX_STR_LEN(4)) dut_lim (
    .clk(clk), .reset(reset), .syscall_valid(syscall_valid_lim), .v0(v0), .a0(a0), .a1(a1),
    .mem_rd(mem_rd_lim), .mem_addr(mem_addr_lim), .mem_rdata(mem_rdata_lim),
    .char_valid(char_valid_lim), .char_data(char_data_lim), .char_ready(char_ready),
    .int_valid(int_valid_lim), .int_data(int_data_lim), .int_ready(int_ready),
    .stall(stall_lim), .halted(halted_lim), .bad_code(bad_code_lim)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    logic [11:0] b;
    b = {addr[11:2], 2'b00};
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  // Data memory answers one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= rd_word(mem_addr);
    if (mem_rd_lim) mem_rdata_lim <= rd_word(mem_addr_lim);
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      char_ready = 1'($urandom_range(0, 1));
      int_ready  = 1'($urandom_range(0, 1));
    end
  end

  // Record every completed console handshake and every memory read.
  always @(negedge clk) begin
    if (!reset) begin
      if (char_valid && char_ready) char_q.push_back(char_data);
      if (int_valid && int_ready) int_q.push_back(int_data);
      if (mem_rd) rd_q.push_back(mem_addr);
      if (char_valid_lim && char_ready) char_lim_q.push_back(char_data_lim);
      if (mem_rd_lim) rd_lim_q.push_back(mem_addr_lim);
    end
  end

  task automatic put_string(input logic [31:0] addr, input int len);
    for (int i = 0; i < len; i++) mem[12'(addr + 32'(i))] = 8'($urandom_range(1, 255));
    mem[12'(addr + 32'(len))] = 8'h00;
  endtask

  // Reference: walk bytes from addr until NUL or maxlen chars; each byte costs one word read.
  task automatic model_string(input logic [31:0] addr, input int maxlen);
    logic [31:0] p;
    p = addr;
    exp_chars = {};
    exp_reads = {};
    for (int k = 0; k < 4096; k++) begin
      exp_reads.push_back({p[31:2], 2'b00});
      if (mem[p[11:0]] == 8'h00) break;
      exp_chars.push_back(mem[p[11:0]]);
      p = p + 32'd1;
      if (exp_chars.size() == maxlen) break;
    end
  endtask

  // Presents a SYSCALL the way writeback does: held while stall is high. Call just after a posedge.
  task automatic run_syscall(input bit lim, input logic [31:0] code, input logic [31:0] arg,
                             input int budget);
    int n;
    v0 = code;
    a0 = arg;
    if (lim) syscall_valid_lim = 1'b1;
    else syscall_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while ((lim ? stall_lim : stall) === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((lim ? stall_lim : stall) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL syscall_done v0=%0d: stall=%b, required 0 within %0d cycles",
               code, lim ? stall_lim : stall, budget);
    end
    @(posedge clk); #1;
    syscall_valid = 1'b0;
    syscall_valid_lim = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 7;
    if (stall !== 1'b0)       begin errors++; $display("[TB] FAIL reset_stall: got %b, required 0", stall); end
    if (halted !== 1'b0)      begin errors++; $display("[TB] FAIL reset_halted: got %b, required 0", halted); end
    if (char_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_char_valid: got %b, required 0", char_valid); end
    if (int_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_int_valid: got %b, required 0", int_valid); end
    if (mem_rd !== 1'b0)      begin errors++; $display("[TB] FAIL reset_mem_rd: got %b, required 0", mem_rd); end
    if (bad_code !== 1'b0)    begin errors++; $display("[TB] FAIL reset_bad_code: got %b, required 0", bad_code); end
    if ({mem_addr, int_data, char_data} !== 72'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got addr=%h int=%h char=%h, required all 0", mem_addr, int_data, char_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || char_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got stall=%b char_valid=%b, required 0 0", stall, char_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_print_char;
    rand_ready = 1'b0;
    char_ready = 1'b0;
    char_q = {};
    syscall_valid = 1'b1;
    v0 = 32'd11;
    a0 = 32'h0000_0041;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (char_valid !== 1'b1 || char_data !== 8'h41 || stall !== 1'b1) begin
        errors++;
        $display("[TB] FAIL char_hold cycle %0d: got valid=%b data=%h stall=%b, required 1 41 1",
                 i, char_valid, char_data, stall);
      end
    end
    @(posedge clk); #1;
    char_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL char_accept_stall: got %b, required 1", stall); end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || char_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL char_release: got stall=%b valid=%b, required 0 0", stall, char_valid);
    end
    @(posedge clk); #1;
    syscall_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (char_q.size() != 1 || char_q[0] !== 8'h41) begin
      errors++;
      $display("[TB] FAIL char_count: got %0d chars, required exactly one 0x41", char_q.size());
    end
    // A few more random characters under random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [31:0] arg;
      arg = $urandom;
      char_q = {};
      run_syscall(1'b0, 32'd11, arg, 300);
      checks++;
      if (char_q.size() != 1 || char_q[0] !== arg[7:0]) begin
        errors++;
        $display("[TB] FAIL char_random: got %0d chars first=%h, required 1 char %h",
                 char_q.size(), char_q.size() > 0 ? char_q[0] : 8'hxx, arg[7:0]);
      end
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_print_string;
    logic [31:0] addr;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        addr = 32'h100;
        {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'h006C6548;
      end else if (t == 1) begin
        addr = 32'h203;
        put_string(addr, 6);
      end else begin
        addr = 32'($urandom_range(32'h300, 32'hE00));
        put_string(addr, $urandom_range(0, 12));
      end
      model_string(addr, 256);
      char_q = {};
      rd_q = {};
      rand_ready = (t >= 2);
      char_ready = 1'b1;
      run_syscall(1'b0, 32'd4, addr, 2000);
      checks++;
      if (char_q.size() != exp_chars.size() || rd_q.size() != exp_reads.size()) begin
        errors++;
        $display("[TB] FAIL string_len a0=%h: got %0d chars %0d reads, required %0d chars %0d reads",
                 addr, char_q.size(), rd_q.size(), exp_chars.size(), exp_reads.size());
      end
      for (int i = 0; i < exp_chars.size() && i < char_q.size(); i++) begin
        checks++;
        if (char_q[i] !== exp_chars[i]) begin
          errors++;
          $display("[TB] FAIL string_char a0=%h idx %0d: got %h, required %h", addr, i, char_q[i], exp_chars[i]);
        end
      end
      for (int i = 0; i < exp_reads.size() && i < rd_q.size(); i++) begin
        checks++;
        if (rd_q[i] !== exp_reads[i]) begin
          errors++;
          $display("[TB] FAIL string_addr a0=%h read %0d: got %h, required %h", addr, i, rd_q[i], exp_reads[i]);
        end
      end
    end
    rand_ready = 1'b0;
    char_ready = 1'b1;
  endtask

  task automatic test_limit;
    logic [31:0] addr;
    for (int t = 0; t < 6; t++) begin
      addr = (t == 0) ? 32'h401 : 32'($urandom_range(32'h500, 32'hE00));
      put_string(addr, (t == 0) ? 8 : $urandom_range(0, 9));
      model_string(addr, 4);
      char_lim_q = {};
      rd_lim_q = {};
      rand_ready = (t > 0);
      char_ready = 1'b1;
      run_syscall(1'b1, 32'd4, addr, 500);
      checks++;
      if (char_lim_q.size() != exp_chars.size() || rd_lim_q.size() != exp_reads.size()) begin
        errors++;
        $display("[TB] FAIL limit_len a0=%h: got %0d chars %0d reads, required %0d chars %0d reads",
                 addr, char_lim_q.size(), rd_lim_q.size(), exp_chars.size(), exp_reads.size());
      end
      for (int i = 0; i < exp_chars.size() && i < char_lim_q.size(); i++) begin
        checks++;
        if (char_lim_q[i] !== exp_chars[i]) begin
          errors++;
          $display("[TB] FAIL limit_char idx %0d: got %h, required %h", i, char_lim_q[i], exp_chars[i]);
        end
      end
    end
    rand_ready = 1'b0;
    char_ready = 1'b1;
  endtask

  task automatic test_print_int;
    logic [31:0] arg;
    for (int t = 0; t < 6; t++) begin
      arg = (t == 0) ? 32'hFFFF_FFF6 : $urandom;
      int_q = {};
      char_q = {};
      rand_ready = (t > 0);
      int_ready = 1'b1;
      run_syscall(1'b0, 32'd1, arg, 300);
      checks++;
      if (int_q.size() != 1 || int_q[0] !== arg || char_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL int_value: got %0d ints first=%h chars=%0d, required 1 int %h 0 chars",
                 int_q.size(), int_q.size() > 0 ? int_q[0] : 32'hx, char_q.size(), arg);
      end
      if (t == 0 && int_q.size() > 0) begin
        checks++;
        if ($signed(int_q[0]) != -10) begin
          errors++;
          $display("[TB] FAIL int_negative: got %0d, required -10", $signed(int_q[0]));
        end
      end
    end
    rand_ready = 1'b0;
    int_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    char_ready = 1'b1;
    int_ready = 1'b1;
    char_q = {};
    int_q = {};
    run_syscall(1'b0, 32'd11, 32'h31, 50);
    run_syscall(1'b0, 32'd1, 32'd123, 50);
    run_syscall(1'b0, 32'd4, 32'h100, 100);
    run_syscall(1'b0, 32'd11, 32'h32, 50);
    checks += 2;
    if (int_q.size() != 1 || int_q[0] !== 32'd123) begin
      errors++;
      $display("[TB] FAIL b2b_int: got %0d ints, required one 123", int_q.size());
    end
    if (char_q.size() != 5 || char_q[0] !== 8'h31 || char_q[1] !== 8'h48 || char_q[4] !== 8'h32) begin
      errors++;
      $display("[TB] FAIL b2b_chars: got %0d chars, required 31 48 65 6c 32", char_q.size());
    end
  endtask

  task automatic test_bad_code;
    logic [31:0] code;
    for (int t = 0; t < 6; t++) begin
      code = (t == 0) ? 32'd7 : $urandom;
      if (code == 32'd1 || code == 32'd4 || code == 32'd10 || code == 32'd11) code = 32'd5;
      syscall_valid = 1'b1;
      v0 = code;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("[TB] FAIL bad_stall v0=%h: got %b, required 0", code, stall); end
      @(posedge clk); #1;
      syscall_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bad_code !== 1'b1 || stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bad_pulse v0=%h: got bad=%b stall=%b, required 1 0", code, bad_code, stall);
      end
      @(negedge clk);
      checks++;
      if (bad_code !== 1'b0) begin errors++; $display("[TB] FAIL bad_width v0=%h: got %b, required 0", code, bad_code); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exit;
    char_ready = 1'b1;
    char_q = {};
    syscall_valid = 1'b1;
    v0 = 32'd10;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) syscall_valid = 1'b0;
      if (i == 3) begin syscall_valid = 1'b1; v0 = 32'd11; a0 = 32'h5A; end
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || stall !== 1'b1 || char_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL exit_hold cycle %0d: got halted=%b stall=%b char_valid=%b, required 1 1 0",
                 i, halted, stall, char_valid);
      end
    end
    checks++;
    if (char_q.size() != 0) begin errors++; $display("[TB] FAIL exit_ignore: got %0d chars, required 0", char_q.size()); end
    @(posedge clk); #1;
    syscall_valid = 1'b0;
  endtask

  task automatic test_reset_mid_service;
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_leaves_halt: got halted=%b stall=%b, required 0 0", halted, stall);
    end
    @(posedge clk); #1;
    char_ready = 1'b0;
    syscall_valid = 1'b1;
    v0 = 32'd4;
    a0 = 32'h100;
    n = 0;
    @(negedge clk);
    while (char_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (char_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_reach_emit: got %b, required 1", char_valid); end
    #2;
    syscall_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({char_valid, int_valid, mem_rd, halted, bad_code, stall} !== 6'b0 ||
        {char_data, int_data, mem_addr} !== 72'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got cv=%b iv=%b rd=%b h=%b bc=%b st=%b cd=%h, required all 0",
               char_valid, int_valid, mem_rd, halted, bad_code, stall, char_data);
    end
    @(negedge clk);
    reset = 1'b0;
    char_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (char_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_after: got char_valid=%b stall=%b, required 0 0", char_valid, stall);
    end
  endtask

  initial begin
    reset = 1'b1;
    syscall_valid = 1'b0;
    syscall_valid_lim = 1'b0;
    v0 = '0;
    a0 = '0;
    a1 = '0;
    char_ready = 1'b0;
    int_ready = 1'b0;
    mem_rdata = '0;
    mem_rdata_lim = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    $display("[TB] starting syscall_unit bench");
    test_reset();
    test_print_char();
    test_print_string();
    test_limit();
    test_print_int();
    test_back_to_back();
    test_bad_code();
    test_exit();
    test_reset_mid_service();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
